// File: rtl/clock_divider_prog.sv
// Programmable integer clock-enable divider: ceil(act/2) high / floor(act/2) low,
// registered edge strobes, shadowed divisor applied only at period boundaries.
module clock_divider_prog #(
    parameter int CNT_W    = 16,
    parameter int DIV_INIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             divided,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             load_pend,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(DIV_INIT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shd;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_end;

    // ceil(act/2) without a carry out of CNT_W bits
    assign half    = (act >> 1) + {{(CNT_W-1){1'b0}}, act[0]};
    assign cnt_inc = cnt + ONE;
    assign at_end  = (cnt == act - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            act       <= INIT_V;
            shd       <= INIT_V;
            divided   <= 1'b1;
            rise_stb  <= 1'b0;
            fall_stb  <= 1'b0;
            load_pend <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;

            if (en) begin
                if (at_end) begin
                    cnt      <= '0;
                    divided  <= 1'b1;
                    rise_stb <= 1'b1;
                    if (load_pend) begin
                        act       <= shd;
                        load_pend <= 1'b0;
                    end
                end else begin
                    cnt <= cnt_inc;
                    if (cnt_inc == half) begin
                        divided  <= 1'b0;
                        fall_stb <= 1'b1;
                    end
                end
            end

            // A load in the boundary cycle stays pending for the next period
            if (div_load) begin
                load_pend <= 1'b1;
                if (div_val < TWO) begin
                    shd     <= TWO;
                    div_err <= 1'b1;
                end else begin
                    shd <= div_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: per-cycle reference model via a
// scoreboard queue, a hand-computed vector table, and strobe-timing sequences.
module tb_clock_divider_prog;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             divided;
    logic             rise_stb;
    logic             fall_stb;
    logic             load_pend;
    logic             div_err;

    always #5 clk = ~clk;

    clock_divider_prog #(.CNT_W(CNT_W), .DIV_INIT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_val   (div_val),
        .div_load  (div_load),
        .divided   (divided),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .load_pend (load_pend),
        .div_err   (div_err)
    );

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    // reference model state: position within period, not a mirror of the RTL counter
    int   m_pos, m_act, m_shd;
    logic m_pend, m_err, m_div, m_rise, m_fall;

    logic [4:0] sb_q[$];

    typedef struct {
        logic             en;
        logic             ld;
        logic [CNT_W-1:0] val;
        logic [4:0]       exp;   // {divided, rise, fall, pend, err}
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%0h expected=%0h", name, ecount, actual, expected);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic l, input logic [CNT_W-1:0] v);
        int np, h;
        if (r) begin
            m_pos = 0; m_act = 32; m_shd = 32; m_pend = 0; m_err = 0;
            m_div = 1; m_rise = 0; m_fall = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (e) begin
                np = (m_pos + 1) % m_act;
                if (np == 0 && m_pend) begin
                    m_act  = m_shd;
                    m_pend = 0;
                end
                m_pos  = np;
                h      = (m_act + 1) / 2;
                m_rise = (np == 0);
                m_fall = (np == h);
                m_div  = (np < h);
            end
            if (l) begin
                if (int'(v) < 2) begin
                    m_shd = 2;
                    m_err = 1;
                end else begin
                    m_shd = int'(v);
                end
                m_pend = 1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic l, input logic [CNT_W-1:0] v);
        logic [4:0] exp;
        rst = r; en = e; div_load = l; div_val = v;
        @(posedge clk);
        model_step(r, e, l, v);
        sb_q.push_back({m_div, m_rise, m_fall, m_pend, m_err});
        ecount = r ? 0 : ecount + 1;
        #1;
        exp = sb_q.pop_front();
        check("outputs", {27'd0, divided, rise_stb, fall_stb, load_pend, div_err}, {27'd0, exp});
        div_load = 1'b0;
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
    endtask

    // run enabled idle cycles until the chosen strobe fires; returns its edge index
    task automatic wait_stb(input bit want_rise, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            cyc(0, 1, 0, '0);
            if (want_rise ? rise_stb : fall_stb) begin
                at = ecount;
                break;
            end
        end
        if (at < 0) check(want_rise ? "rise_timeout" : "fall_timeout", 0, 1);
    endtask

    initial begin
        int at;
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_val = '0;

        // act=3 running, illegal load, act=2 toggling, load while disabled
        tbl[0]  = '{1, 0, 0, 5'b10000};
        tbl[1]  = '{1, 0, 0, 5'b00100};
        tbl[2]  = '{1, 1, 1, 5'b11011};
        tbl[3]  = '{1, 0, 0, 5'b10011};
        tbl[4]  = '{0, 0, 0, 5'b10011};
        tbl[5]  = '{1, 0, 0, 5'b00111};
        tbl[6]  = '{1, 0, 0, 5'b11001};
        tbl[7]  = '{1, 0, 0, 5'b00101};
        tbl[8]  = '{1, 0, 0, 5'b11001};
        tbl[9]  = '{0, 1, 9, 5'b10011};
        tbl[10] = '{1, 0, 0, 5'b00111};
        tbl[11] = '{1, 0, 0, 5'b11001};
        tbl[12] = '{1, 0, 0, 5'b10001};

        // default divide-by-32
        do_reset();
        check("reset_state", {27'd0, divided, rise_stb, fall_stb, load_pend, div_err}, 32'b10000);
        wait_stb(0, 40, at); check("default_fall", at, 16);
        wait_stb(1, 40, at); check("default_rise1", at, 32);
        wait_stb(1, 40, at); check("default_rise2", at, 64);

        // ratio change mid-period
        do_reset();
        repeat (10) cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 16'd5);
        check("pend_after_load", load_pend, 1);
        repeat (20) cyc(0, 1, 0, '0);
        check("pend_before_bound", load_pend, 1);
        wait_stb(1, 10, at); check("ratio_rise", at, 32);
        check("pend_cleared", load_pend, 0);
        wait_stb(0, 10, at); check("ratio5_fall", at, 35);
        wait_stb(1, 10, at); check("ratio5_rise", at, 37);

        // vector table starting from a fresh act=3 period
        do_reset();
        cyc(0, 1, 1, 16'd3);
        wait_stb(1, 40, at); check("act3_applied", at, 32);
        for (int i = 0; i < 13; i++) begin
            cyc(0, tbl[i].en, tbl[i].ld, tbl[i].val);
            check($sformatf("table_%0d", i),
                  {27'd0, divided, rise_stb, fall_stb, load_pend, div_err}, {27'd0, tbl[i].exp});
        end

        // enable gating at cnt=20
        do_reset();
        repeat (20) cyc(0, 1, 0, '0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, '0);
            check("gap_quiet", {29'd0, divided, rise_stb, fall_stb}, 0);
        end
        wait_stb(1, 40, at); check("gated_rise", at, 42);

        // load in the boundary cycle, then two loads in one period
        do_reset();
        repeat (31) cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 16'd7);
        check("collide_rise", rise_stb, 1);
        check("collide_pend", load_pend, 1);
        wait_stb(1, 40, at); check("collide_keep32", at, 64);
        check("collide_pend_clr", load_pend, 0);
        wait_stb(1, 40, at); check("collide_rise7", at, 71);
        repeat (2) cyc(0, 1, 0, '0);
        cyc(0, 1, 1, 16'd9);
        cyc(0, 1, 1, 16'd4);
        wait_stb(1, 20, at); check("last_load_rise", at, 78);
        wait_stb(0, 20, at); check("div4_fall", at, 80);
        wait_stb(1, 20, at); check("div4_rise", at, 82);

        // reset mid-operation with a pending load and sticky error
        do_reset();
        cyc(0, 1, 1, 16'd1);
        cyc(0, 1, 1, 16'd6);
        repeat (23) cyc(0, 1, 0, '0);
        check("pre_reset_err", {30'd0, load_pend, div_err}, 32'b11);
        cyc(1, 1, 0, '0);
        check("midrst_state", {27'd0, divided, rise_stb, fall_stb, load_pend, div_err}, 32'b10000);
        wait_stb(0, 40, at); check("midrst_fall", at, 16);
        wait_stb(1, 40, at); check("midrst_rise", at, 32);
        wait_stb(1, 40, at); check("midrst_rise2", at, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Programmable, parametrised successor to the fixed divide-by-32 clock divider. It generates a divided clock-enable waveform from the single system clock with a runtime-selectable integer ratio and near-50% duty for odd ratios. It provides registered rise/fall strobes for downstream logic, plus a glitch-free ratio change applied only at period boundaries. It feeds the PE module's slow-rate logic; `divided` is a logic-level signal, not a clock-tree clock.

## Interface
- `CNT_W`, 16, width of the divisor and the period counter; maximum divisor is 2^CNT_W-1.
- `DIV_INIT`, 32, divisor after reset; legal range 2..2^CNT_W-1.

- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: count enable; when low, all state holds.
- `div_val` in CNT_W: new divisor value, sampled when `div_load`=1.
- `div_load` in 1: single-cycle request to load `div_val` into the shadow register.
- `divided` out 1: divided output, registered.
- `rise_stb` out 1: one-cycle pulse in the cycle in which `divided` becomes 1.
- `fall_stb` out 1: one-cycle pulse in the cycle in which `divided` becomes 0.
- `load_pend` out 1: the shadow divisor has not yet been applied.
- `div_err` out 1: sticky flag, set when an illegal divisor (<2) is loaded.

## Operation
- **State:** `cnt` (CNT_W bits), active divisor `act`, shadow divisor `shd`, pending flag, error flag.
- **High-phase length:** H = (act>>1) + act[0], i.e. ceil(act/2). Compute it without widening overflow.
- **Waveform:** the period is `act` enabled cycles. `divided` is high for H cycles and low for act-H cycles.
- **Boundary:** an enabled edge with cnt == act-1. On that edge:
  - cnt <= 0, divided <= 1, rise_stb <= 1.
  - If pending: act <= shd, pending <= 0.
- **Fall:** an enabled, non-boundary edge with cnt+1 == H. On that edge: cnt <= cnt+1, divided <= 0, fall_stb <= 1.
- **Other enabled edges:** cnt <= cnt+1, and both strobes <= 0.
- **en=0:**
  - cnt, divided, act and pending hold.
  - Both strobes <= 0.
  - `div_load` is still accepted into the shadow register.
- **div_load:**
  - shd <= div_val and pending <= 1.
  - If div_val < 2: shd <= 2 and div_err <= 1. `div_err` stays set until `rst`.
  - A second load while pending overwrites shd; only the last value is applied.
- **Simultaneous div_load and boundary:**
  - The boundary applies the previous shd if pending was set; otherwise act is unchanged.
  - The newly loaded value stays pending until the next boundary.
- **Reset values:** cnt=0, divided=1, rise_stb=0, fall_stb=0, act=DIV_INIT, shd=DIV_INIT, load_pend=0, div_err=0.
- **Reset mid-operation:** all state returns to the reset values on that edge, and any pending shadow value is discarded.
- **First period after reset:** no `rise_stb`, because `divided` is already 1.

## Timing
- All outputs are registered. Strobes coincide with the new `divided` level, not one cycle ahead of it.
- **DIV_INIT=32, en=1 from the first edge after rst release:**
  - `divided` is high for cycles 0..15 and low for 16..31.
  - `fall_stb` in cycle 16; `rise_stb` in cycle 32.
  - Period 32, identical to the previous fixed block.
- **act=3:** high 2 cycles, low 1. **act=2:** toggles every cycle, with `rise_stb` and `fall_stb` alternating.
- **Load latency:** `load_pend` rises the cycle after `div_load`. It clears in the first cycle of the new period, which is the same cycle as `rise_stb`.
- **en deassertion:** stretches the current phase by exactly the number of disabled cycles. No partial periods; no glitches.

## Test plan
- **Default divide:** rst 2 cycles, en=1, no loads → `divided` 16 high / 16 low. `fall_stb` at cycle 16, `rise_stb` at cycles 32 and 64. `load_pend`=0 and `div_err`=0 throughout.
- **Ratio change mid-period:** load 5 at cycle 10 → `load_pend`=1 from cycle 11 to cycle 32. From cycle 32 the output repeats 3 high / 2 low, with `rise_stb` every 5 cycles and `fall_stb` 3 cycles after each rise.
- **Illegal load:** load 1 → `div_err`=1 and stays set. After the next boundary `divided` toggles every cycle (act=2).
- **Enable gating:** drop en for 10 cycles at cnt=20 (act=32) → `divided` stays 0, no strobes during the gap. The next `rise_stb` arrives exactly 10 cycles later than nominal.
- **Boundary collisions:**
  - Load 7 while pending=0, in the boundary cycle → act stays 32 for one more period; 7 is applied at the following boundary.
  - Loads 9 then 4 in the same period → only 4 (high 2 / low 2) is applied.
- **Reset mid-operation:** rst at cnt=25 with a pending load of 6 and `div_err`=1 → next cycle `divided`=1, `load_pend`=0, `div_err`=0. Thereafter the output repeats the 32-cycle pattern.
